// File: rtl/axi4_lite_xbar_pkg.sv
// rtl/axi4_lite_xbar_pkg.sv - address map, response codes and index constants for the 2x2 AXI4-Lite crossbar
// Optional feature macro used by the crossbar: AXI4_LITE_XBAR_DECERR_EN
package axi4_lite_xbar_pkg;

  localparam logic [31:0] S1_BASE  = 32'h0000_2000;
  localparam logic [31:0] S2_BASE  = 32'h0000_3000;
  localparam logic [31:0] SLV_MASK = 32'hFFFF_F000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic MST_M1 = 1'b0;
  localparam logic MST_M2 = 1'b1;
  localparam int   SLV_S1 = 0;
  localparam int   SLV_S2 = 1;

  typedef enum logic {CH_WRITE = 1'b0, CH_READ = 1'b1} chan_e;

  // One-hot slave select; all-zero means the address hits no slave.
  function automatic logic [1:0] decode(input logic [31:0] addr);
    logic [1:0] hit;
    hit = 2'b00;
    if ((addr & SLV_MASK) == S1_BASE) hit[SLV_S1] = 1'b1;
    if ((addr & SLV_MASK) == S2_BASE) hit[SLV_S2] = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/axi4_lite_xbar_arbiter.sv
// rtl/axi4_lite_xbar_arbiter.sv - 2-way round-robin arbiter, combinational one-hot grant
module axi4_lite_xbar_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  import axi4_lite_xbar_pkg::*;

  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = (ptr == MST_M2) ? 2'b10 : 2'b01;
  end

  // Pointer only moves when both masters contend, so a lone requester never shifts fairness.
  always_ff @(posedge clk) begin
    if (reset) ptr <= MST_M1;
    else if (req == 2'b11) ptr <= ~ptr;
  end

endmodule

// File: rtl/axi4_lite_crossbar.sv
// rtl/axi4_lite_crossbar.sv - 2-master x 2-slave AXI4-Lite crossbar without ready handshakes
// Optional: define AXI4_LITE_XBAR_DECERR_EN to answer unmapped addresses with DECERR.
module axi4_lite_crossbar (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] awaddr_in_m1,
  input  logic [2:0]  awprot_in_m1,
  input  logic        awvalid_in_m1,
  input  logic [31:0] awaddr_in_m2,
  input  logic [2:0]  awprot_in_m2,
  input  logic        awvalid_in_m2,
  output logic [31:0] awaddr_out_s1,
  output logic [2:0]  awprot_out_s1,
  output logic        awvalid_out_s1,
  output logic [31:0] awaddr_out_s2,
  output logic [2:0]  awprot_out_s2,
  output logic        awvalid_out_s2,
  input  logic [31:0] wdata_in_m1,
  input  logic [3:0]  wstrb_in_m1,
  input  logic        wvalid_in_m1,
  input  logic [31:0] wdata_in_m2,
  input  logic [3:0]  wstrb_in_m2,
  input  logic        wvalid_in_m2,
  output logic [31:0] wdata_out_s1,
  output logic [3:0]  wstrb_out_s1,
  output logic        wvalid_out_s1,
  output logic [31:0] wdata_out_s2,
  output logic [3:0]  wstrb_out_s2,
  output logic        wvalid_out_s2,
  output logic [1:0]  bresp_out_m1,
  output logic        bvalid_out_m1,
  output logic [1:0]  bresp_out_m2,
  output logic        bvalid_out_m2,
  input  logic [1:0]  bresp_in_s1,
  input  logic        bvalid_in_s1,
  input  logic [1:0]  bresp_in_s2,
  input  logic        bvalid_in_s2,
  input  logic [31:0] araddr_in_m1,
  input  logic [2:0]  arprot_in_m1,
  input  logic        arvalid_in_m1,
  input  logic [31:0] araddr_in_m2,
  input  logic [2:0]  arprot_in_m2,
  input  logic        arvalid_in_m2,
  output logic [31:0] araddr_out_s1,
  output logic [2:0]  arprot_out_s1,
  output logic        arvalid_out_s1,
  output logic [31:0] araddr_out_s2,
  output logic [2:0]  arprot_out_s2,
  output logic        arvalid_out_s2,
  output logic [31:0] rdata_out_m1,
  output logic        rvalid_out_m1,
  output logic [1:0]  rresp_out_m1,
  output logic [31:0] rdata_out_m2,
  output logic        rvalid_out_m2,
  output logic [1:0]  rresp_out_m2,
  input  logic [31:0] rdata_in_s1,
  input  logic        rvalid_in_s1,
  input  logic [1:0]  rresp_in_s1,
  input  logic [31:0] rdata_in_s2,
  input  logic        rvalid_in_s2,
  input  logic [1:0]  rresp_in_s2
);
  import axi4_lite_xbar_pkg::*;

  logic [1:0][31:0] aw_addr, w_data, ar_addr;
  logic [1:0][2:0]  aw_prot, ar_prot;
  logic [1:0][3:0]  w_strb;
  logic [1:0]       aw_v, w_v, ar_v;

  assign aw_addr = {awaddr_in_m2, awaddr_in_m1};
  assign aw_prot = {awprot_in_m2, awprot_in_m1};
  assign aw_v    = {awvalid_in_m2, awvalid_in_m1};
  assign w_data  = {wdata_in_m2, wdata_in_m1};
  assign w_strb  = {wstrb_in_m2, wstrb_in_m1};
  assign w_v     = {wvalid_in_m2, wvalid_in_m1};
  assign ar_addr = {araddr_in_m2, araddr_in_m1};
  assign ar_prot = {arprot_in_m2, arprot_in_m1};
  assign ar_v    = {arvalid_in_m2, arvalid_in_m1};

  logic [1:0][1:0] aw_dec, ar_dec;    // [master][slave]
  logic [1:0][1:0] wreq, rreq;        // [slave][master]
  logic [1:0][1:0] wgrant, rgrant;    // [slave][master]
  logic [1:0][1:0] dec_err;           // [chan][master]

  always_comb begin
    aw_dec  = '0;
    ar_dec  = '0;
    wreq    = '0;
    rreq    = '0;
    dec_err = '0;
    for (int n = 0; n < 2; n++) begin
      aw_dec[n] = decode(aw_addr[n]);
      ar_dec[n] = decode(ar_addr[n]);
      for (int k = 0; k < 2; k++) begin
        wreq[k][n] = aw_v[n] & w_v[n] & aw_dec[n][k];
        rreq[k][n] = ar_v[n] & ar_dec[n][k];
      end
`ifdef AXI4_LITE_XBAR_DECERR_EN
      dec_err[CH_WRITE][n] = aw_v[n] & w_v[n] & (aw_dec[n] == 2'b00);
      dec_err[CH_READ][n]  = ar_v[n] & (ar_dec[n] == 2'b00);
`endif
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_arb
    axi4_lite_xbar_arbiter u_warb (.clk(aclk), .reset(areset), .req(wreq[k]), .grant(wgrant[k]));
    axi4_lite_xbar_arbiter u_rarb (.clk(aclk), .reset(areset), .req(rreq[k]), .grant(rgrant[k]));
  end

  logic [1:0][31:0] aw_addr_q, w_data_q, ar_addr_q;
  logic [1:0][2:0]  aw_prot_q, ar_prot_q;
  logic [1:0][3:0]  w_strb_q;
  logic [1:0]       aw_v_q, ar_v_q;
  logic [1:0][1:0]  owner;            // [chan][slave], 0 = M1

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_addr_q <= '0; aw_prot_q <= '0; w_data_q <= '0; w_strb_q <= '0; aw_v_q <= '0;
      ar_addr_q <= '0; ar_prot_q <= '0; ar_v_q <= '0;
      owner     <= {2{MST_M1, MST_M1}};
    end else begin
      for (int k = 0; k < 2; k++) begin
        aw_v_q[k] <= |wgrant[k];
        ar_v_q[k] <= |rgrant[k];
        if (|wgrant[k]) begin
          aw_addr_q[k]       <= aw_addr[wgrant[k][1]];
          aw_prot_q[k]       <= aw_prot[wgrant[k][1]];
          w_data_q[k]        <= w_data[wgrant[k][1]];
          w_strb_q[k]        <= w_strb[wgrant[k][1]];
          owner[CH_WRITE][k] <= wgrant[k][1];
        end
        if (|rgrant[k]) begin
          ar_addr_q[k]      <= ar_addr[rgrant[k][1]];
          ar_prot_q[k]      <= ar_prot[rgrant[k][1]];
          owner[CH_READ][k] <= rgrant[k][1];
        end
      end
    end
  end

  logic [1:0][1:0]      rsp_v;        // [chan][slave]
  logic [1:0][1:0][1:0] rsp_r;        // [chan][slave]
  logic [1:0][31:0]     rsp_d;        // [slave]

  assign rsp_v = {{rvalid_in_s2, rvalid_in_s1}, {bvalid_in_s2, bvalid_in_s1}};
  assign rsp_r = {{rresp_in_s2, rresp_in_s1}, {bresp_in_s2, bresp_in_s1}};
  assign rsp_d = {rdata_in_s2, rdata_in_s1};

  logic [1:0][1:0]      hit_s1, hit_s2;                 // [chan][master]
  logic [1:0][1:0]      pend_v, out_v, nx_pend_v, nx_out_v;
  logic [1:0][1:0][1:0] pend_r, out_r, nx_pend_r, nx_out_r;
  logic [1:0][31:0]     pend_d, out_d, nx_pend_d, nx_out_d;  // read data only

  // S1 wins a same-cycle collision; the S2 response parks one cycle and then outranks new S1 traffic.
  always_comb begin
    hit_s1    = '0;
    hit_s2    = '0;
    nx_pend_v = pend_v;
    nx_pend_r = pend_r;
    nx_pend_d = pend_d;
    nx_out_v  = '0;
    nx_out_r  = out_r;
    nx_out_d  = out_d;
    for (int c = 0; c < 2; c++) begin
      for (int n = 0; n < 2; n++) begin
        hit_s1[c][n] = rsp_v[c][0] & (owner[c][0] == 1'(n));
        hit_s2[c][n] = rsp_v[c][1] & (owner[c][1] == 1'(n));
        if (hit_s1[c][n] && !pend_v[c][n]) begin
          nx_out_v[c][n] = 1'b1;
          nx_out_r[c][n] = rsp_r[c][0];
          if (c == int'(CH_READ)) nx_out_d[n] = rsp_d[0];
          nx_pend_v[c][n] = hit_s2[c][n];
          if (hit_s2[c][n]) begin
            nx_pend_r[c][n] = rsp_r[c][1];
            if (c == int'(CH_READ)) nx_pend_d[n] = rsp_d[1];
          end
        end else if (pend_v[c][n]) begin
          nx_out_v[c][n] = 1'b1;
          nx_out_r[c][n] = pend_r[c][n];
          if (c == int'(CH_READ)) nx_out_d[n] = pend_d[n];
          nx_pend_v[c][n] = hit_s2[c][n];
          if (hit_s2[c][n]) begin
            nx_pend_r[c][n] = rsp_r[c][1];
            if (c == int'(CH_READ)) nx_pend_d[n] = rsp_d[1];
          end
        end else if (hit_s2[c][n]) begin
          nx_out_v[c][n] = 1'b1;
          nx_out_r[c][n] = rsp_r[c][1];
          if (c == int'(CH_READ)) nx_out_d[n] = rsp_d[1];
        end else if (dec_err[c][n]) begin
          nx_out_v[c][n] = 1'b1;
          nx_out_r[c][n] = RESP_DECERR;
          if (c == int'(CH_READ)) nx_out_d[n] = '0;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      out_v  <= '0; out_r  <= '0; out_d  <= '0;
      pend_v <= '0; pend_r <= '0; pend_d <= '0;
    end else begin
      out_v  <= nx_out_v;  out_r  <= nx_out_r;  out_d  <= nx_out_d;
      pend_v <= nx_pend_v; pend_r <= nx_pend_r; pend_d <= nx_pend_d;
    end
  end

  assign awaddr_out_s1  = aw_addr_q[0];
  assign awprot_out_s1  = aw_prot_q[0];
  assign awvalid_out_s1 = aw_v_q[0];
  assign awaddr_out_s2  = aw_addr_q[1];
  assign awprot_out_s2  = aw_prot_q[1];
  assign awvalid_out_s2 = aw_v_q[1];
  assign wdata_out_s1   = w_data_q[0];
  assign wstrb_out_s1   = w_strb_q[0];
  assign wvalid_out_s1  = aw_v_q[0];
  assign wdata_out_s2   = w_data_q[1];
  assign wstrb_out_s2   = w_strb_q[1];
  assign wvalid_out_s2  = aw_v_q[1];
  assign araddr_out_s1  = ar_addr_q[0];
  assign arprot_out_s1  = ar_prot_q[0];
  assign arvalid_out_s1 = ar_v_q[0];
  assign araddr_out_s2  = ar_addr_q[1];
  assign arprot_out_s2  = ar_prot_q[1];
  assign arvalid_out_s2 = ar_v_q[1];

  assign bresp_out_m1  = out_r[CH_WRITE][0];
  assign bvalid_out_m1 = out_v[CH_WRITE][0];
  assign bresp_out_m2  = out_r[CH_WRITE][1];
  assign bvalid_out_m2 = out_v[CH_WRITE][1];
  assign rdata_out_m1  = out_d[0];
  assign rvalid_out_m1 = out_v[CH_READ][0];
  assign rresp_out_m1  = out_r[CH_READ][0];
  assign rdata_out_m2  = out_d[1];
  assign rvalid_out_m2 = out_v[CH_READ][1];
  assign rresp_out_m2  = out_r[CH_READ][1];

endmodule

// File: tb/tb_axi4_lite_crossbar.sv
// tb/tb_axi4_lite_crossbar.sv - directed self-checking bench for axi4_lite_crossbar
module tb_axi4_lite_crossbar;

  logic        aclk, areset;
  logic [31:0] awaddr_in_m1, awaddr_in_m2, awaddr_out_s1, awaddr_out_s2;
  logic [2:0]  awprot_in_m1, awprot_in_m2, awprot_out_s1, awprot_out_s2;
  logic        awvalid_in_m1, awvalid_in_m2, awvalid_out_s1, awvalid_out_s2;
  logic [31:0] wdata_in_m1, wdata_in_m2, wdata_out_s1, wdata_out_s2;
  logic [3:0]  wstrb_in_m1, wstrb_in_m2, wstrb_out_s1, wstrb_out_s2;
  logic        wvalid_in_m1, wvalid_in_m2, wvalid_out_s1, wvalid_out_s2;
  logic [1:0]  bresp_out_m1, bresp_out_m2, bresp_in_s1, bresp_in_s2;
  logic        bvalid_out_m1, bvalid_out_m2, bvalid_in_s1, bvalid_in_s2;
  logic [31:0] araddr_in_m1, araddr_in_m2, araddr_out_s1, araddr_out_s2;
  logic [2:0]  arprot_in_m1, arprot_in_m2, arprot_out_s1, arprot_out_s2;
  logic        arvalid_in_m1, arvalid_in_m2, arvalid_out_s1, arvalid_out_s2;
  logic [31:0] rdata_out_m1, rdata_out_m2, rdata_in_s1, rdata_in_s2;
  logic        rvalid_out_m1, rvalid_out_m2, rvalid_in_s1, rvalid_in_s2;
  logic [1:0]  rresp_out_m1, rresp_out_m2, rresp_in_s1, rresp_in_s2;

  int checks = 0;
  int errors = 0;

  axi4_lite_crossbar dut (
    .aclk(aclk), .areset(areset),
    .awaddr_in_m1(awaddr_in_m1), .awprot_in_m1(awprot_in_m1), .awvalid_in_m1(awvalid_in_m1),
    .awaddr_in_m2(awaddr_in_m2), .awprot_in_m2(awprot_in_m2), .awvalid_in_m2(awvalid_in_m2),
    .awaddr_out_s1(awaddr_out_s1), .awprot_out_s1(awprot_out_s1), .awvalid_out_s1(awvalid_out_s1),
    .awaddr_out_s2(awaddr_out_s2), .awprot_out_s2(awprot_out_s2), .awvalid_out_s2(awvalid_out_s2),
    .wdata_in_m1(wdata_in_m1), .wstrb_in_m1(wstrb_in_m1), .wvalid_in_m1(wvalid_in_m1),
    .wdata_in_m2(wdata_in_m2), .wstrb_in_m2(wstrb_in_m2), .wvalid_in_m2(wvalid_in_m2),
    .wdata_out_s1(wdata_out_s1), .wstrb_out_s1(wstrb_out_s1), .wvalid_out_s1(wvalid_out_s1),
    .wdata_out_s2(wdata_out_s2), .wstrb_out_s2(wstrb_out_s2), .wvalid_out_s2(wvalid_out_s2),
    .bresp_out_m1(bresp_out_m1), .bvalid_out_m1(bvalid_out_m1),
    .bresp_out_m2(bresp_out_m2), .bvalid_out_m2(bvalid_out_m2),
    .bresp_in_s1(bresp_in_s1), .bvalid_in_s1(bvalid_in_s1),
    .bresp_in_s2(bresp_in_s2), .bvalid_in_s2(bvalid_in_s2),
    .araddr_in_m1(araddr_in_m1), .arprot_in_m1(arprot_in_m1), .arvalid_in_m1(arvalid_in_m1),
    .araddr_in_m2(araddr_in_m2), .arprot_in_m2(arprot_in_m2), .arvalid_in_m2(arvalid_in_m2),
    .araddr_out_s1(araddr_out_s1), .arprot_out_s1(arprot_out_s1), .arvalid_out_s1(arvalid_out_s1),
    .araddr_out_s2(araddr_out_s2), .arprot_out_s2(arprot_out_s2), .arvalid_out_s2(arvalid_out_s2),
    .rdata_out_m1(rdata_out_m1), .rvalid_out_m1(rvalid_out_m1), .rresp_out_m1(rresp_out_m1),
    .rdata_out_m2(rdata_out_m2), .rvalid_out_m2(rvalid_out_m2), .rresp_out_m2(rresp_out_m2),
    .rdata_in_s1(rdata_in_s1), .rvalid_in_s1(rvalid_in_s1), .rresp_in_s1(rresp_in_s1),
    .rdata_in_s2(rdata_in_s2), .rvalid_in_s2(rvalid_in_s2), .rresp_in_s2(rresp_in_s2)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    awaddr_in_m1 = '0; awprot_in_m1 = '0; awvalid_in_m1 = 0;
    awaddr_in_m2 = '0; awprot_in_m2 = '0; awvalid_in_m2 = 0;
    wdata_in_m1 = '0; wstrb_in_m1 = '0; wvalid_in_m1 = 0;
    wdata_in_m2 = '0; wstrb_in_m2 = '0; wvalid_in_m2 = 0;
    araddr_in_m1 = '0; arprot_in_m1 = '0; arvalid_in_m1 = 0;
    araddr_in_m2 = '0; arprot_in_m2 = '0; arvalid_in_m2 = 0;
    bresp_in_s1 = '0; bvalid_in_s1 = 0; bresp_in_s2 = '0; bvalid_in_s2 = 0;
    rdata_in_s1 = '0; rvalid_in_s1 = 0; rresp_in_s1 = '0;
    rdata_in_s2 = '0; rvalid_in_s2 = 0; rresp_in_s2 = '0;
  endtask

  initial begin
    clr_in();
    // Reset with live inputs: every output must stay zero
    areset = 1;
    awaddr_in_m1 = 32'h2000; awvalid_in_m1 = 1; wvalid_in_m1 = 1; wdata_in_m1 = 32'hDEAD;
    araddr_in_m2 = 32'h3000; arvalid_in_m2 = 1; bvalid_in_s1 = 1; bresp_in_s1 = 2'd2;
    rvalid_in_s2 = 1; rdata_in_s2 = 32'h55;
    tick();
    chk("rst_awvalid_s1", awvalid_out_s1, 0);
    chk("rst_awaddr_s1", awaddr_out_s1, 0);
    chk("rst_wdata_s1", wdata_out_s1, 0);
    chk("rst_arvalid_s2", arvalid_out_s2, 0);
    chk("rst_bvalid_m1", bvalid_out_m1, 0);
    chk("rst_rvalid_m1", rvalid_out_m1, 0);
    chk("rst_rdata_m1", rdata_out_m1, 0);

    // Basic write M1 -> S1
    areset = 0; clr_in();
    awaddr_in_m1 = 32'h2000; awvalid_in_m1 = 1; wdata_in_m1 = 32'h12345678; wstrb_in_m1 = 4'd2; wvalid_in_m1 = 1;
    tick();
    chk("wr_awvalid_s1", awvalid_out_s1, 1);
    chk("wr_wvalid_s1", wvalid_out_s1, 1);
    chk("wr_awaddr_s1", awaddr_out_s1, 32'h2000);
    chk("wr_wdata_s1", wdata_out_s1, 32'h12345678);
    chk("wr_wstrb_s1", wstrb_out_s1, 4'd2);
    chk("wr_awvalid_s2", awvalid_out_s2, 0);
    clr_in();
    bresp_in_s1 = 2'd2; bvalid_in_s1 = 1;
    tick();
    chk("wr_bvalid_m1", bvalid_out_m1, 1);
    chk("wr_bresp_m1", bresp_out_m1, 2);
    chk("wr_bvalid_m2", bvalid_out_m2, 0);
    chk("wr_awvalid_s1_drop", awvalid_out_s1, 0);
    chk("wr_awaddr_s1_hold", awaddr_out_s1, 32'h2000);
    clr_in();
    tick();
    chk("wr_bvalid_m1_idle", bvalid_out_m1, 0);
    chk("wr_bresp_m1_hold", bresp_out_m1, 2);

    // Read M1 -> S2 at the top boundary of S2
    araddr_in_m1 = 32'h3FFF; arprot_in_m1 = 3'd5; arvalid_in_m1 = 1;
    tick();
    chk("rd_arvalid_s2", arvalid_out_s2, 1);
    chk("rd_araddr_s2", araddr_out_s2, 32'h3FFF);
    chk("rd_arprot_s2", arprot_out_s2, 5);
    chk("rd_arvalid_s1", arvalid_out_s1, 0);
    clr_in();
    rdata_in_s2 = 32'hFEDCBA09; rresp_in_s2 = 2'd3; rvalid_in_s2 = 1;
    tick();
    chk("rd_rvalid_m1", rvalid_out_m1, 1);
    chk("rd_rdata_m1", rdata_out_m1, 32'hFEDCBA09);
    chk("rd_rresp_m1", rresp_out_m1, 3);
    clr_in();
    tick();

    // Concurrent M1->S1 and M2->S2
    awaddr_in_m1 = 32'h2222; wdata_in_m1 = 32'hAAAA0001; wstrb_in_m1 = 4'hF; awvalid_in_m1 = 1; wvalid_in_m1 = 1;
    awaddr_in_m2 = 32'h3222; wdata_in_m2 = 32'hBBBB0002; wstrb_in_m2 = 4'h1; awvalid_in_m2 = 1; wvalid_in_m2 = 1;
    tick();
    chk("cc_awvalid_s1", awvalid_out_s1, 1);
    chk("cc_awvalid_s2", awvalid_out_s2, 1);
    chk("cc_awaddr_s1", awaddr_out_s1, 32'h2222);
    chk("cc_wdata_s1", wdata_out_s1, 32'hAAAA0001);
    chk("cc_awaddr_s2", awaddr_out_s2, 32'h3222);
    chk("cc_wdata_s2", wdata_out_s2, 32'hBBBB0002);
    chk("cc_wstrb_s2", wstrb_out_s2, 4'h1);
    clr_in();
    bresp_in_s1 = 2'd1; bvalid_in_s1 = 1; bresp_in_s2 = 2'd2; bvalid_in_s2 = 1;
    tick();
    chk("cc_bvalid_m1", bvalid_out_m1, 1);
    chk("cc_bresp_m1", bresp_out_m1, 1);
    chk("cc_bvalid_m2", bvalid_out_m2, 1);
    chk("cc_bresp_m2", bresp_out_m2, 2);
    clr_in();
    tick();

    // Contention on S1: M1 first, then M2, responses follow the owner
    awaddr_in_m1 = 32'h2444; wdata_in_m1 = 32'h44; awvalid_in_m1 = 1; wvalid_in_m1 = 1;
    awaddr_in_m2 = 32'h2555; wdata_in_m2 = 32'h55; awvalid_in_m2 = 1; wvalid_in_m2 = 1;
    tick();
    chk("rr_first_addr", awaddr_out_s1, 32'h2444);
    chk("rr_first_data", wdata_out_s1, 32'h44);
    awvalid_in_m1 = 0; wvalid_in_m1 = 0;
    bresp_in_s1 = 2'd0; bvalid_in_s1 = 1;
    tick();
    chk("rr_second_valid", awvalid_out_s1, 1);
    chk("rr_second_addr", awaddr_out_s1, 32'h2555);
    chk("rr_second_data", wdata_out_s1, 32'h55);
    chk("rr_b_m1_valid", bvalid_out_m1, 1);
    chk("rr_b_m1_resp", bresp_out_m1, 0);
    chk("rr_b_m2_idle", bvalid_out_m2, 0);
    clr_in();
    bresp_in_s1 = 2'd2; bvalid_in_s1 = 1;
    tick();
    chk("rr_b_m2_valid", bvalid_out_m2, 1);
    chk("rr_b_m2_resp", bresp_out_m2, 2);
    chk("rr_b_m1_idle", bvalid_out_m1, 0);
    chk("rr_awvalid_idle", awvalid_out_s1, 0);
    clr_in();
    // Pointer toggled by the earlier contest: M2 wins this one
    awaddr_in_m1 = 32'h2010; awvalid_in_m1 = 1; wvalid_in_m1 = 1;
    awaddr_in_m2 = 32'h2020; awvalid_in_m2 = 1; wvalid_in_m2 = 1;
    tick();
    chk("rr_toggle_addr", awaddr_out_s1, 32'h2020);
    clr_in();
    tick();

    // Both slaves answer M1 in one cycle: S1 first, S2 next
    araddr_in_m1 = 32'h2100; arvalid_in_m1 = 1;
    tick();
    chk("col_arvalid_s1", arvalid_out_s1, 1);
    clr_in();
    rdata_in_s1 = 32'h11111111; rresp_in_s1 = 2'd0; rvalid_in_s1 = 1;
    rdata_in_s2 = 32'h22222222; rresp_in_s2 = 2'd1; rvalid_in_s2 = 1;
    tick();
    chk("col_first_valid", rvalid_out_m1, 1);
    chk("col_first_data", rdata_out_m1, 32'h11111111);
    chk("col_first_resp", rresp_out_m1, 0);
    clr_in();
    tick();
    chk("col_second_valid", rvalid_out_m1, 1);
    chk("col_second_data", rdata_out_m1, 32'h22222222);
    chk("col_second_resp", rresp_out_m1, 1);
    tick();
    chk("col_idle_valid", rvalid_out_m1, 0);
    chk("col_idle_hold", rdata_out_m1, 32'h22222222);

    // Unmapped addresses
    awaddr_in_m1 = 32'h1234; awvalid_in_m1 = 1; wvalid_in_m1 = 1;
    araddr_in_m2 = 32'h0001_3DDD; arvalid_in_m2 = 1;
    tick();
    chk("dec_awvalid_s1", awvalid_out_s1, 0);
    chk("dec_awvalid_s2", awvalid_out_s2, 0);
    chk("dec_arvalid_s1", arvalid_out_s1, 0);
    chk("dec_arvalid_s2", arvalid_out_s2, 0);
`ifdef AXI4_LITE_XBAR_DECERR_EN
    chk("dec_bvalid_m1", bvalid_out_m1, 1);
    chk("dec_bresp_m1", bresp_out_m1, 3);
    chk("dec_rvalid_m2", rvalid_out_m2, 1);
    chk("dec_rresp_m2", rresp_out_m2, 3);
`else
    chk("dec_bvalid_m1", bvalid_out_m1, 0);
    chk("dec_rvalid_m2", rvalid_out_m2, 0);
`endif
    clr_in();
    tick();

    // Reset mid-traffic with an S2 response parked for M1
    awaddr_in_m1 = 32'h2000; awvalid_in_m1 = 1; wvalid_in_m1 = 1;
    araddr_in_m2 = 32'h3000; arvalid_in_m2 = 1;
    rdata_in_s1 = 32'hA1; rvalid_in_s1 = 1; rdata_in_s2 = 32'hA2; rvalid_in_s2 = 1;
    tick();
    chk("mid_awvalid_s1", awvalid_out_s1, 1);
    chk("mid_rdata_m1", rdata_out_m1, 32'hA1);
    areset = 1;
    tick();
    chk("mid_rst_awvalid_s1", awvalid_out_s1, 0);
    chk("mid_rst_awaddr_s1", awaddr_out_s1, 0);
    chk("mid_rst_arvalid_s2", arvalid_out_s2, 0);
    chk("mid_rst_araddr_s2", araddr_out_s2, 0);
    chk("mid_rst_rvalid_m1", rvalid_out_m1, 0);
    chk("mid_rst_rdata_m1", rdata_out_m1, 0);
    chk("mid_rst_bvalid_m1", bvalid_out_m1, 0);
    areset = 0; clr_in();
    tick();
    chk("mid_no_pending", rvalid_out_m1, 0);
    chk("mid_no_pending_data", rdata_out_m1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
